midi_msg_sequencer: RTL and testbench
=====================================

MIDI_MSG_SEQUENCER -- requirements
Module: midi_msg_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, message FIFO entries; power of two, 2..16.
REQ-002 clock  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 byte_in  input  8  received serial byte from the UART byte receiver.
REQ-005 byte_strobe  input  1  one-cycle pulse; byte_in valid in that cycle.
REQ-006 msg_valid  output  1  FIFO head holds a complete message.
REQ-007 msg_ready  input  1  consumer accepts head when msg_valid&&msg_ready.
REQ-008 msg_status  output  8  status byte of head message.
REQ-009 msg_data1 / msg_data2  output  8 each  data bytes; unused bytes read 8'h00.
REQ-010 msg_len  output  2  byte count of head message, 1..3.
REQ-011 overflow  output  1  sticky; set on any message dropped at full FIFO.
REQ-012 drop_cnt  output  8  count of dropped messages, saturating at 255.

Function
REQ-013 Parser states SHALL be IDLE, WAIT_D1, WAIT_D2, SYSEX; all transitions occur only on byte_strobe cycles.
REQ-014 Status 8'h80-8'hEF SHALL set running status; 8'hC0-8'hDF need 1 data byte, others need 2; next state WAIT_D1.
REQ-015 Data byte (bit7=0) in WAIT_D1 SHALL store data1, then complete (1-data status) or go WAIT_D2; in WAIT_D2 SHALL store data2 and complete.
REQ-016 On completing a channel message, state SHALL return to WAIT_D1 with running status retained.
REQ-017 Data byte in IDLE (no running status) SHALL be discarded.
REQ-018 8'hF0 SHALL enter SYSEX and clear running status; data bytes in SYSEX discarded; 8'hF7 returns to IDLE; any other non-realtime status exits SYSEX and is processed normally.
REQ-019 System common 8'hF1/8'hF3 need 1 data byte, 8'hF2 needs 2, 8'hF6 completes immediately with msg_len=1; all clear running status and return to IDLE on completion.
REQ-020 8'hF4, 8'hF5, stray 8'hF7 SHALL clear running status, go IDLE, emit nothing.
REQ-021 Realtime 8'hF8-8'hFF SHALL NOT change parser state, running status or partial data (see REQ-029).
REQ-022 New status byte arriving mid-message SHALL abandon the partial message without emission.
REQ-023 Latency: byte_strobe in cycle N completing a message SHALL write FIFO at edge ending N+1; msg_valid high from cycle N+2 when FIFO was empty.
REQ-024 FIFO SHALL be first-word-fall-through; msg_* outputs reflect head while msg_valid, all zero when empty.
REQ-025 Push at full without simultaneous pop SHALL drop the new message, set overflow, increment drop_cnt (saturate 255).
REQ-026 Push and pop in the same cycle at full SHALL accept both; occupancy unchanged, no overflow.
REQ-027 msg_ready while msg_valid low SHALL have no effect.

Reset
REQ-028 reset SHALL force state IDLE, running status cleared, partial bytes cleared, FIFO empty, msg_valid=0, msg_status/msg_data1/msg_data2=0, msg_len=0, overflow=0, drop_cnt=0; reset mid-message discards it; byte_strobe during reset ignored.

Configuration
REQ-029 Macro MIDI_REALTIME_PASS_EN defined: each realtime byte SHALL be pushed as a msg_len=1 message, interleaved in arrival order, without disturbing a partial message; undefined: realtime bytes SHALL be discarded with no FIFO or counter effect.

Structure
REQ-030 Package midi_pkg SHALL hold parser state enum, status-byte constants (SYSEX_START, SYSEX_END, TUNE_REQ, REALTIME_BASE), message struct typedef, and a data-length function of status byte.
REQ-031 FIFO SHALL be sub-module midi_msg_fifo (synchronous, FIFO_DEPTH entries of message struct, full/empty flags).

Verification
REQ-032 Strobes 8'h90,8'h3C,8'h64 -> one message status 8'h90, data 8'h3C/8'h64, len 3, msg_valid two cycles after third strobe.
REQ-033 After REQ-032, strobes 8'h40,8'h00 with ready=1 -> second message 8'h90/8'h40/8'h00 (running status).
REQ-034 8'hF0,8'h7E,8'h01,8'hF7 then 8'hC5,8'h07 -> only message 8'hC5/8'h07/8'h00, len 2.
REQ-035 8'h90,8'hF8,8'h3C,8'h64: with MIDI_REALTIME_PASS_EN -> 8'hF8 len1 then 8'h90 note; without -> note only.
REQ-036 msg_ready=0, FIFO_DEPTH=4, six complete 8'hF6 messages -> four queued, overflow=1, drop_cnt=2; reset mid-message -> all outputs zero, next 8'h3C discarded.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI parser types, status-byte constants and helpers.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        SYSEX
    } parse_state_t;

    localparam logic [7:0] SYSEX_START   = 8'hF0;
    localparam logic [7:0] SYSEX_END     = 8'hF7;
    localparam logic [7:0] TUNE_REQ      = 8'hF6;
    localparam logic [7:0] REALTIME_BASE = 8'hF8;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] data1;
        logic [7:0] data2;
        logic [1:0] len;
    } midi_msg_t;

    // Data bytes that follow a status byte; zero for the no-payload codes.
    function automatic logic [1:0] data_len(input logic [7:0] s);
        logic [1:0] n;
        n = 2'd0;
        case (s[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd2;
            4'hC, 4'hD:                   n = 2'd1;
            4'hF: begin
                case (s[3:0])
                    4'h1, 4'h3: n = 2'd1;
                    4'h2:       n = 2'd2;
                    default:    n = 2'd0;
                endcase
            end
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic midi_msg_t mk_msg(
        input logic [7:0] s,
        input logic [7:0] d1,
        input logic [7:0] d2,
        input logic [1:0] l
    );
        midi_msg_t m;
        m.status = s;
        m.data1  = d1;
        m.data2  = d2;
        m.len    = l;
        return m;
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// First-word-fall-through message FIFO; head reads all-zero when empty.
module midi_msg_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  midi_msg_t push_msg,
    input  logic      pop,
    output midi_msg_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    midi_msg_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign wr_en = push && (!full || rd_en);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_msg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/midi_msg_sequencer.sv
// MIDI byte-stream parser with running status feeding a message FIFO.
// Define MIDI_REALTIME_PASS_EN to forward realtime bytes as 1-byte messages.
module midi_msg_sequencer
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_strobe,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [7:0] msg_data1,
    output logic [7:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       overflow,
    output logic [7:0] drop_cnt
);

    parse_state_t state;
    logic         rs_valid;
    logic [7:0]   cur_status;
    logic [1:0]   need;
    logic [7:0]   data1_q;
    logic         push_q;
    midi_msg_t    push_msg;
    midi_msg_t    head;
    logic         full;
    logic         empty;
    logic         pop;
    logic         drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rs_valid   <= 1'b0;
            cur_status <= 8'h00;
            need       <= 2'd0;
            data1_q    <= 8'h00;
            push_q     <= 1'b0;
            push_msg   <= '0;
        end else begin
            push_q <= 1'b0;
            if (byte_strobe) begin
                if (byte_in >= REALTIME_BASE) begin
`ifdef MIDI_REALTIME_PASS_EN
                    push_q   <= 1'b1;
                    push_msg <= mk_msg(byte_in, 8'h00, 8'h00, 2'd1);
`endif
                end else if (byte_in[7]) begin
                    unique case (1'b1)
                        (byte_in < SYSEX_START): begin
                            rs_valid   <= 1'b1;
                            cur_status <= byte_in;
                            need       <= data_len(byte_in);
                            state      <= WAIT_D1;
                        end
                        (byte_in == SYSEX_START): begin
                            rs_valid <= 1'b0;
                            state    <= SYSEX;
                        end
                        (byte_in == TUNE_REQ): begin
                            rs_valid <= 1'b0;
                            state    <= IDLE;
                            push_q   <= 1'b1;
                            push_msg <= mk_msg(byte_in, 8'h00, 8'h00, 2'd1);
                        end
                        (byte_in inside {8'hF1, 8'hF2, 8'hF3}): begin
                            rs_valid   <= 1'b0;
                            cur_status <= byte_in;
                            need       <= data_len(byte_in);
                            state      <= WAIT_D1;
                        end
                        default: begin
                            rs_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    endcase
                end else begin
                    // Channel messages stay in WAIT_D1 for running status.
                    unique case (state)
                        WAIT_D1: begin
                            data1_q <= byte_in;
                            if (need == 2'd1) begin
                                push_q   <= 1'b1;
                                push_msg <= mk_msg(cur_status, byte_in,
                                                   8'h00, 2'd2);
                                state    <= rs_valid ? WAIT_D1 : IDLE;
                            end else begin
                                state <= WAIT_D2;
                            end
                        end
                        WAIT_D2: begin
                            push_q   <= 1'b1;
                            push_msg <= mk_msg(cur_status, data1_q,
                                               byte_in, 2'd3);
                            state    <= rs_valid ? WAIT_D1 : IDLE;
                        end
                        default: begin
                            state <= state;
                        end
                    endcase
                end
            end
        end
    end

    assign pop  = msg_ready && !empty;
    assign drop = push_q && full && !pop;

    midi_msg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_q),
        .push_msg (push_msg),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'h01;
            end
        end
    end

    assign msg_valid  = !empty;
    assign msg_status = head.status;
    assign msg_data1  = head.data1;
    assign msg_data2  = head.data2;
    assign msg_len    = head.len;

endmodule

// File: tb/tb_midi_msg_sequencer.sv
// Scoreboard testbench for midi_msg_sequencer.
module tb_midi_msg_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_strobe;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [7:0] msg_data1;
    logic [7:0] msg_data2;
    logic [1:0] msg_len;
    logic       overflow;
    logic [7:0] drop_cnt;

    int passed = 0;
    int total  = 0;
    logic [25:0] sb [$];

    always #5 clock = ~clock;

    midi_msg_sequencer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_strobe (byte_strobe),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_status  (msg_status),
        .msg_data1   (msg_data1),
        .msg_data2   (msg_data2),
        .msg_len     (msg_len),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    // Scoreboard consumer: every accepted head must match the oldest expectation.
    always @(negedge clock) begin
        logic [25:0] got;
        logic [25:0] exp;
        if (!reset && msg_valid && msg_ready) begin
            got = {msg_status, msg_data1, msg_data2, msg_len};
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_msg: got %h required none", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp)
                    $display("FAIL msg_compare: got %h required %h", got, exp);
                else
                    passed++;
            end
        end
    end

    function automatic logic [25:0] m(input logic [7:0] s, input logic [7:0] d1,
                                      input logic [7:0] d2, input logic [1:0] l);
        return {s, d1, d2, l};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in     = b;
        byte_strobe = 1'b1;
        idle(1);
        byte_strobe = 1'b0;
        byte_in     = 8'h00;
    endtask

    task automatic drain();
        msg_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
        idle(2);
        msg_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        byte_in = 8'h00; byte_strobe = 1'b0; msg_ready = 1'b0;
        do_reset();
        total++;
        if (msg_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", msg_valid);
        else passed++;
        total++;
        if ({msg_status, msg_data1, msg_data2, msg_len} !== 26'h0)
            $display("FAIL rst_msg: got %h required 0",
                     {msg_status, msg_data1, msg_data2, msg_len});
        else passed++;
        total++;
        if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b required 0", overflow);
        else passed++;
        total++;
        if (drop_cnt !== 8'h00) $display("FAIL rst_drop: got %h required 00", drop_cnt);
        else passed++;
    endtask

    task automatic test_note_latency();
        send(8'h90); send(8'h3C); send(8'h64);
        total++;
        if (msg_valid !== 1'b0) $display("FAIL lat_n1: got %b required 0", msg_valid);
        else passed++;
        idle(1);
        total++;
        if (msg_valid !== 1'b1) $display("FAIL lat_n2: got %b required 1", msg_valid);
        else passed++;
        total++;
        if ({msg_status, msg_data1, msg_data2, msg_len} !== m(8'h90, 8'h3C, 8'h64, 2'd3))
            $display("FAIL note_head: got %h required %h",
                     {msg_status, msg_data1, msg_data2, msg_len},
                     m(8'h90, 8'h3C, 8'h64, 2'd3));
        else passed++;
        sb.push_back(m(8'h90, 8'h3C, 8'h64, 2'd3));
        drain();
        total++;
        if (msg_status !== 8'h00 || msg_len !== 2'd0)
            $display("FAIL empty_zero: got %h/%0d required 00/0", msg_status, msg_len);
        else passed++;
    endtask

    task automatic test_running_status();
        msg_ready = 1'b1;
        sb.push_back(m(8'h90, 8'h40, 8'h00, 2'd3));
        send(8'h40); send(8'h00);
        drain();
        total++;
        if (sb.size() != 0) $display("FAIL running_timeout: got %0d left required 0", sb.size());
        else passed++;
    endtask

    task automatic test_sysex();
        sb.push_back(m(8'hC5, 8'h07, 8'h00, 2'd2));
        send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7);
        send(8'hC5); send(8'h07);
        drain();
        total++;
        if (sb.size() != 0) $display("FAIL sysex_timeout: got %0d left required 0", sb.size());
        else passed++;
    endtask

    task automatic test_realtime();
`ifdef MIDI_REALTIME_PASS_EN
        sb.push_back(m(8'hF8, 8'h00, 8'h00, 2'd1));
`endif
        sb.push_back(m(8'h90, 8'h3C, 8'h64, 2'd3));
        send(8'h90); send(8'hF8); send(8'h3C); send(8'h64);
        drain();
        total++;
        if (sb.size() != 0) $display("FAIL rt_timeout: got %0d left required 0", sb.size());
        else passed++;
    endtask

    task automatic test_sys_common();
        sb.push_back(m(8'hF1, 8'h12, 8'h00, 2'd2));
        sb.push_back(m(8'hF2, 8'h01, 8'h02, 2'd3));
        sb.push_back(m(8'h80, 8'h3C, 8'h40, 2'd3));
        send(8'hF1); send(8'h12);
        send(8'hF2); send(8'h01); send(8'h02);
        send(8'h55);
        send(8'h90); send(8'h3C); send(8'hF4); send(8'h64);
        send(8'h90); send(8'h3C); send(8'h80); send(8'h3C); send(8'h40);
        drain();
        total++;
        if (sb.size() != 0) $display("FAIL common_timeout: got %0d left required 0", sb.size());
        else passed++;
        total++;
        if (msg_valid !== 1'b0) $display("FAIL common_extra: got %b required 0", msg_valid);
        else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (6) send(8'hF6);
        idle(3);
        total++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b required 1", overflow);
        else passed++;
        total++;
        if (drop_cnt !== 8'd2) $display("FAIL ovf_drop: got %0d required 2", drop_cnt);
        else passed++;
        repeat (4) sb.push_back(m(8'hF6, 8'h00, 8'h00, 2'd1));
        sb.push_back(m(8'hF6, 8'h00, 8'h00, 2'd1));
        send(8'hF6);
        msg_ready = 1'b1;
        idle(1);
        msg_ready = 1'b0;
        idle(1);
        total++;
        if (drop_cnt !== 8'd2) $display("FAIL pushpop_full: got %0d required 2", drop_cnt);
        else passed++;
        drain();
        total++;
        if (sb.size() != 0) $display("FAIL ovf_timeout: got %0d left required 0", sb.size());
        else passed++;
    endtask

    task automatic test_drop_saturate();
        do_reset();
        repeat (262) send(8'hF6);
        idle(3);
        total++;
        if (drop_cnt !== 8'd255) $display("FAIL drop_sat: got %0d required 255", drop_cnt);
        else passed++;
        repeat (4) sb.push_back(m(8'hF6, 8'h00, 8'h00, 2'd1));
        drain();
        total++;
        if (sb.size() != 0) $display("FAIL sat_timeout: got %0d left required 0", sb.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        send(8'hF6);
        send(8'h90); send(8'h3C);
        idle(2);
        reset = 1'b1;
        byte_in = 8'h64; byte_strobe = 1'b1;
        idle(1);
        byte_strobe = 1'b0; byte_in = 8'h00;
        idle(1);
        reset = 1'b0;
        total++;
        if ({msg_valid, msg_status, msg_data1, msg_data2, msg_len, overflow, drop_cnt} !== 36'h0)
            $display("FAIL rst_mid_out: got %h required 0",
                     {msg_valid, msg_status, msg_data1, msg_data2, msg_len, overflow, drop_cnt});
        else passed++;
        send(8'h3C);
        idle(3);
        total++;
        if (msg_valid !== 1'b0) $display("FAIL rst_mid_discard: got %b required 0", msg_valid);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_note_latency();
        test_running_status();
        test_sysex();
        test_realtime();
        test_sys_common();
        test_overflow();
        test_drop_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
